// File: rtl/crc_pkg.sv
// Shared constants and FSM state type for the serial CRC generator/checker pair.
package crc_pkg;

  localparam int CRC_W_DEF    = 6;
  localparam int POLY_DEF     = 'h15;
  localparam int DATA_LEN_DEF = 8;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    CHECK
  } state_e;

endpackage

// File: rtl/crc_check_if.sv
// Serial-in / result-out bundle between the deserialiser and the CRC checker.
// err_count exists only when CRC_ERRCNT_EN is defined.
interface crc_check_if
  import crc_pkg::*;
#(
  parameter int CRC_W    = CRC_W_DEF,
  parameter int DATA_LEN = DATA_LEN_DEF
);
  logic                inputbit;
  logic                bit_valid;
  logic                frame_start;
  logic                busy;
  logic                done;
  logic                crc_ok;
  logic                crc_err;
  logic [CRC_W-1:0]    syndrome;
  logic [DATA_LEN-1:0] data_out;
`ifdef CRC_ERRCNT_EN
  logic [7:0]          err_count;
`endif

  modport master (
`ifdef CRC_ERRCNT_EN
    input  err_count,
`endif
    output inputbit, bit_valid, frame_start,
    input  busy, done, crc_ok, crc_err, syndrome, data_out
  );

  modport slave (
`ifdef CRC_ERRCNT_EN
    output err_count,
`endif
    input  inputbit, bit_valid, frame_start,
    output busy, done, crc_ok, crc_err, syndrome, data_out
  );
endinterface

// File: rtl/crc_lfsr.sv
// Galois CRC LFSR, one bit per enabled cycle; clr restarts from zero (combined with en
// it absorbs the first bit from r=0). r_next exposes the post-shift value.
module crc_lfsr
  import crc_pkg::*;
#(
  parameter int               CRC_W = CRC_W_DEF,
  parameter logic [CRC_W-1:0] POLY  = CRC_W'(POLY_DEF)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] r_next
);
  logic [CRC_W-1:0] r_q, r_d, r_base;
  logic             fb;

  always_comb begin
    r_base = clr ? '0 : r_q;
    fb     = bit_in ^ r_base[CRC_W-1];
    r_next = {r_base[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    r_d    = en ? r_next : r_base;
  end

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_q <= '0;
    else        r_q <= r_d;
  end
endmodule

// File: rtl/crc_check.sv
// Serial CRC checker: MSB-first payload then check bits; zero residue means a good frame.
// Optional saturating error counter on err_count when CRC_ERRCNT_EN is defined.
module crc_check
  import crc_pkg::*;
#(
  parameter int               CRC_W    = CRC_W_DEF,
  parameter logic [CRC_W-1:0] POLY     = CRC_W'(POLY_DEF),
  parameter int               DATA_LEN = DATA_LEN_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
  crc_check_if.slave  bus
);
  localparam int CNT_W = $clog2(DATA_LEN + CRC_W);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_LEN-1:0] payload_q, payload_d;
  logic [DATA_LEN-1:0] data_out_q, data_out_d;
  logic [CRC_W-1:0]    syndrome_q, syndrome_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                crc_ok_q, crc_ok_d;
  logic                crc_err_q, crc_err_d;
  logic [CRC_W-1:0]    r_next;
  logic                start, lfsr_en, last_bit;
`ifdef CRC_ERRCNT_EN
  logic [7:0]          err_cnt_q, err_cnt_d;
`endif

  assign start    = bus.bit_valid & bus.frame_start;
  assign lfsr_en  = start | (bus.bit_valid & (state_q != IDLE));
  assign last_bit = bus.bit_valid & ~start & (state_q == CHECK) &
                    (cnt_q == CNT_W'(DATA_LEN + CRC_W - 1));

  crc_lfsr #(.CRC_W(CRC_W), .POLY(POLY)) u_lfsr (
    .clk    (clk),
    .rst_n  (reset_n),
    .clr    (start),
    .en     (lfsr_en),
    .bit_in (bus.inputbit),
    .r_next (r_next)
  );

  // NOTE: every variable gets a hold/default value first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    payload_d  = payload_q;
    data_out_d = data_out_q;
    syndrome_d = syndrome_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    crc_ok_d   = crc_ok_q;
    crc_err_d  = crc_err_q;
`ifdef CRC_ERRCNT_EN
    err_cnt_d  = err_cnt_q;
`endif
    // A frame_start always wins: it opens a new frame and silently drops any partial one.
    if (start) begin
      state_d   = (DATA_LEN == 1) ? CHECK : DATA;
      cnt_d     = CNT_W'(1);
      payload_d = DATA_LEN'(bus.inputbit);
      busy_d    = 1'b1;
    end else if (bus.bit_valid) begin
      case (state_q)
        DATA: begin
          cnt_d     = cnt_q + CNT_W'(1);
          payload_d = (payload_q << 1) | DATA_LEN'(bus.inputbit);
          if (cnt_q == CNT_W'(DATA_LEN - 1)) state_d = CHECK;
        end
        CHECK: begin
          if (last_bit) begin
            state_d    = IDLE;
            cnt_d      = '0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
            syndrome_d = r_next;
            crc_ok_d   = (r_next == '0);
            crc_err_d  = (r_next != '0);
            data_out_d = payload_q;
`ifdef CRC_ERRCNT_EN
            if ((r_next != '0) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      payload_q  <= '0;
      data_out_q <= '0;
      syndrome_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      crc_ok_q   <= 1'b0;
      crc_err_q  <= 1'b0;
`ifdef CRC_ERRCNT_EN
      err_cnt_q  <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      payload_q  <= payload_d;
      data_out_q <= data_out_d;
      syndrome_q <= syndrome_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      crc_ok_q   <= crc_ok_d;
      crc_err_q  <= crc_err_d;
`ifdef CRC_ERRCNT_EN
      err_cnt_q  <= err_cnt_d;
`endif
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.crc_ok   = crc_ok_q;
  assign bus.crc_err  = crc_err_q;
  assign bus.syndrome = syndrome_q;
  assign bus.data_out = data_out_q;
`ifdef CRC_ERRCNT_EN
  assign bus.err_count = err_cnt_q;
`endif
endmodule
